// File: rtl/wb_access_sched.sv
// wb_access_sched: shares the single-port weight-buffer SRAM between a
// burst-read sequencer (compute side) and the host write path.
// One read command (base, len, bypass) becomes a stream of registered read
// strobes. Host writes take idle or stalled cycles. When a pending write has
// been blocked MAX_WAIT cycles in a row, it gets one forced slot.
// Optional feature macro: WB_SCHED_PERF_EN adds stall and forced-write
// performance counters. Without it, o_perf_* are tied to zero.
module wb_access_sched #(
  parameter int AW       = 13,
  parameter int DW       = 416,
  parameter int MAX_WAIT = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  // read command
  input  logic            i_cmd_vld,
  output logic            o_cmd_rdy,
  input  logic [AW-1:0]   i_cmd_base,
  input  logic [AW-1:0]   i_cmd_len,
  input  logic            i_cmd_bypass,
  input  logic            i_stall,
  // host write
  input  logic            i_hw_vld,
  output logic            o_hw_rdy,
  input  logic [AW-1:0]   i_hw_addr,
  input  logic [DW-1:0]   i_hw_data,
  input  logic [DW/8-1:0] i_hw_be,
  // weight buffer side
  output logic            o_wb_rd_en,
  output logic [AW-1:0]   o_wb_raddr,
  output logic            o_bypass_wb,
  output logic            o_wb_bramctl_en,
  output logic            o_wb_bramctl_we,
  output logic [AW-1:0]   o_wb_bramctl_addr,
  output logic [DW-1:0]   o_wb_bramctl_wdata,
  output logic [DW/8-1:0] o_wb_bramctl_be,
  // status
  output logic            o_busy,
  output logic            o_done,
  output logic [31:0]     o_perf_stall,
  output logic [31:0]     o_perf_steal
);

  localparam int BW  = DW / 8;
  localparam int WCW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_cmd_rdy;
  logic            r_busy;
  logic            r_done;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_remain;
  logic            r_bypass;
  logic [WCW-1:0]  r_wait_cnt;

  logic            r_rd_en;
  logic [AW-1:0]   r_raddr;
  logic            r_bypass_wb;
  logic            r_wr_en;
  logic [AW-1:0]   r_wr_addr;
  logic [DW-1:0]   r_wr_data;
  logic [BW-1:0]   r_wr_be;

  logic            w_run;
  logic            w_wait_full;
  logic            w_read_slot;
  logic            w_hw_acc;
  logic            w_cmd_acc;

  // Slot arbitration. A read wins unless stalled or the write starvation
  // limit has been reached. Otherwise the slot goes to the host. The
  // !i_rst term keeps o_hw_rdy low while reset is held.
  assign w_run       = (r_state == S_RUN);
  assign w_wait_full = (r_wait_cnt >= WCW'(MAX_WAIT));
  assign w_read_slot = w_run & ~i_stall & ~w_wait_full;
  assign w_hw_acc    = i_hw_vld & ~w_read_slot & ~i_rst;
  assign w_cmd_acc   = r_cmd_rdy & i_cmd_vld;

  // Burst sequencer FSM with registered handshake and status outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_cmd_rdy <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rd_ptr  <= '0;
      r_remain  <= '0;
      r_bypass  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_cmd_acc) begin
            r_rd_ptr  <= i_cmd_base;
            r_remain  <= i_cmd_len;
            r_bypass  <= i_cmd_bypass;
            r_state   <= S_RUN;
            r_cmd_rdy <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_read_slot) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
            if (r_remain == '0) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
            end else begin
              r_remain <= r_remain - AW'(1);
            end
          end
        end
        S_DONE: begin
          r_state   <= S_IDLE;
          r_done    <= 1'b1;
          r_cmd_rdy <= 1'b1;
        end
        default: begin
          r_state   <= S_IDLE;
          r_cmd_rdy <= 1'b1;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  // Registered read port: the strobe appears one cycle after its decision.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_en     <= 1'b0;
      r_raddr     <= '0;
      r_bypass_wb <= 1'b0;
    end else begin
      r_rd_en     <= w_read_slot;
      r_bypass_wb <= w_read_slot & r_bypass;
      if (w_read_slot) begin
        r_raddr <= r_rd_ptr;
      end
    end
  end

  // Registered write port: capture the accepted host write for the next cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_be   <= '0;
    end else begin
      r_wr_en <= w_hw_acc;
      if (w_hw_acc) begin
        r_wr_addr <= i_hw_addr;
        r_wr_data <= i_hw_data;
        r_wr_be   <= i_hw_be;
      end
    end
  end

  // Starvation counter: counts blocked cycles of a pending write, saturating.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wait_cnt <= '0;
    end else if (w_hw_acc) begin
      r_wait_cnt <= '0;
    end else if (i_hw_vld && !w_wait_full) begin
      r_wait_cnt <= r_wait_cnt + WCW'(1);
    end
  end

`ifdef WB_SCHED_PERF_EN
  logic        w_forced;
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_steal;

  // A forced slot is a write that won only because the read was starved out.
  assign w_forced = w_run & ~i_stall & w_wait_full & i_hw_vld;

  // Performance counters: stalled burst cycles and forced write slots.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_perf_stall <= '0;
      r_perf_steal <= '0;
    end else begin
      if (w_run && i_stall) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
      if (w_forced) begin
        r_perf_steal <= r_perf_steal + 32'd1;
      end
    end
  end

  assign o_perf_stall = r_perf_stall;
  assign o_perf_steal = r_perf_steal;
`else
  assign o_perf_stall = 32'd0;
  assign o_perf_steal = 32'd0;
`endif

  assign o_cmd_rdy          = r_cmd_rdy;
  assign o_hw_rdy           = w_hw_acc;
  assign o_wb_rd_en         = r_rd_en;
  assign o_wb_raddr         = r_raddr;
  assign o_bypass_wb        = r_bypass_wb;
  assign o_wb_bramctl_en    = r_wr_en;
  assign o_wb_bramctl_we    = r_wr_en;
  assign o_wb_bramctl_addr  = r_wr_addr;
  assign o_wb_bramctl_wdata = r_wr_data;
  assign o_wb_bramctl_be    = r_wr_be;
  assign o_busy             = r_busy;
  assign o_done             = r_done;

endmodule

// File: tb/tb_wb_access_sched.sv
// Directed testbench for wb_access_sched. Cycle 0 of every burst is the
// command-accept cycle. Inputs are driven at posedge+1 and outputs are
// sampled at negedge.
module tb_wb_access_sched;

  localparam int AW = 13;
  localparam int DW = 416;
  localparam int BW = DW / 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_vld;
  logic            cmd_rdy;
  logic [AW-1:0]   cmd_base;
  logic [AW-1:0]   cmd_len;
  logic            cmd_bypass;
  logic            stall;
  logic            hw_vld;
  logic            hw_rdy;
  logic [AW-1:0]   hw_addr;
  logic [DW-1:0]   hw_data;
  logic [BW-1:0]   hw_be;
  logic            rd_en;
  logic [AW-1:0]   raddr;
  logic            bypass_wb;
  logic            bc_en;
  logic            bc_we;
  logic [AW-1:0]   bc_addr;
  logic [DW-1:0]   bc_wdata;
  logic [BW-1:0]   bc_be;
  logic            busy;
  logic            done;
  logic [31:0]     perf_stall;
  logic [31:0]     perf_steal;

  int errors = 0;
  int checks = 0;

  // Per-burst observation records filled by run_burst.
  int            rd_cyc[$];
  logic [AW-1:0] rd_addr[$];
  logic          rd_byp[$];
  int            acc_cyc[$];
  int            wr_cyc[$];
  logic [AW-1:0] wr_addr_q[$];
  logic [DW-1:0] wr_data_last;
  logic [BW-1:0] wr_be_last;
  logic          wr_we_ok;
  int            done_cyc;
  int            busy_cnt;
  logic          rdy_c0;
  logic          rdy_c1;

  wb_access_sched #(.AW(AW), .DW(DW), .MAX_WAIT(16)) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_cmd_vld          (cmd_vld),
    .o_cmd_rdy          (cmd_rdy),
    .i_cmd_base         (cmd_base),
    .i_cmd_len          (cmd_len),
    .i_cmd_bypass       (cmd_bypass),
    .i_stall            (stall),
    .i_hw_vld           (hw_vld),
    .o_hw_rdy           (hw_rdy),
    .i_hw_addr          (hw_addr),
    .i_hw_data          (hw_data),
    .i_hw_be            (hw_be),
    .o_wb_rd_en         (rd_en),
    .o_wb_raddr         (raddr),
    .o_bypass_wb        (bypass_wb),
    .o_wb_bramctl_en    (bc_en),
    .o_wb_bramctl_we    (bc_we),
    .o_wb_bramctl_addr  (bc_addr),
    .o_wb_bramctl_wdata (bc_wdata),
    .o_wb_bramctl_be    (bc_be),
    .o_busy             (busy),
    .o_done             (done),
    .o_perf_stall       (perf_stall),
    .o_perf_steal       (perf_steal)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    rst        = 1'b1;
    cmd_vld    = 1'b0;
    cmd_base   = '0;
    cmd_len    = '0;
    cmd_bypass = 1'b0;
    stall      = 1'b0;
    hw_vld     = 1'b0;
    hw_addr    = '0;
    hw_data    = '0;
    hw_be      = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic sample(input int c);
    #4;
    if (c == 0) rdy_c0 = cmd_rdy;
    if (c == 1) rdy_c1 = cmd_rdy;
    if (rd_en) begin
      rd_cyc.push_back(c);
      rd_addr.push_back(raddr);
      rd_byp.push_back(bypass_wb);
    end
    if (done && done_cyc < 0) done_cyc = c;
    if (busy) busy_cnt++;
    if (hw_vld && hw_rdy) acc_cyc.push_back(c);
    if (bc_en) begin
      wr_cyc.push_back(c);
      wr_addr_q.push_back(bc_addr);
      wr_data_last = bc_wdata;
      wr_be_last   = bc_be;
      if (!bc_we) wr_we_ok = 1'b0;
    end
  endtask

  // Issue one command and record every cycle until o_done or a cycle budget.
  task automatic run_burst(input logic [AW-1:0] base, input logic [AW-1:0] len,
                           input logic byp, input logic [127:0] stall_m,
                           input logic [127:0] hw_m);
    int c;
    rd_cyc.delete(); rd_addr.delete(); rd_byp.delete();
    acc_cyc.delete(); wr_cyc.delete(); wr_addr_q.delete();
    done_cyc = -1; busy_cnt = 0; wr_we_ok = 1'b1;
    c = 0;
    @(posedge clk); #1;
    cmd_vld = 1'b1; cmd_base = base; cmd_len = len; cmd_bypass = byp;
    stall = stall_m[0]; hw_vld = hw_m[0];
    sample(c);
    while (done_cyc < 0 && c < 300) begin
      c++;
      @(posedge clk); #1;
      cmd_vld = 1'b0;
      stall  = (c < 128) ? stall_m[c] : 1'b0;
      hw_vld = (c < 128) ? hw_m[c] : 1'b0;
      sample(c);
    end
    @(posedge clk); #1;
    stall = 1'b0; hw_vld = 1'b0;
    $display("burst base=%h len=%0d byp=%0b reads=%0d writes=%0d done_cycle=%0d",
             base, len, byp, rd_cyc.size(), acc_cyc.size(), done_cyc);
  endtask

  task automatic test_reset();
    apply_reset();
    #4;
    checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL reset_cmd_rdy got=%b exp=1", cmd_rdy); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (rd_en !== 1'b0 || raddr !== '0) begin errors++; $display("FAIL reset_rd got_en=%b got_addr=%h exp=0", rd_en, raddr); end
    checks++; if (bc_en !== 1'b0 || bc_we !== 1'b0 || hw_rdy !== 1'b0) begin errors++; $display("FAIL reset_wr got_en=%b we=%b hw_rdy=%b exp=0", bc_en, bc_we, hw_rdy); end
    checks++; if (perf_stall !== 32'd0 || perf_steal !== 32'd0) begin errors++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", perf_stall, perf_steal); end
    $display("reset checked");
  endtask

  task automatic test_basic();
    apply_reset();
    run_burst(13'h010, 13'd3, 1'b0, '0, '0);
    checks++; if (rd_cyc.size() != 4) begin errors++; $display("FAIL basic_count got=%0d exp=4", rd_cyc.size()); end
    for (int i = 0; i < 4 && i < rd_cyc.size(); i++) begin
      checks++;
      if (rd_addr[i] !== 13'h010 + 13'(i) || rd_cyc[i] != 2 + i || rd_byp[i] !== 1'b0) begin
        errors++;
        $display("FAIL basic_read%0d got addr=%h cyc=%0d byp=%b exp addr=%h cyc=%0d byp=0",
                 i, rd_addr[i], rd_cyc[i], rd_byp[i], 13'h010 + 13'(i), 2 + i);
      end
    end
    checks++; if (done_cyc != 6) begin errors++; $display("FAIL basic_done got=%0d exp=6", done_cyc); end
    checks++; if (busy_cnt != 4) begin errors++; $display("FAIL basic_busy got=%0d exp=4", busy_cnt); end
    checks++; if (rdy_c0 !== 1'b1 || rdy_c1 !== 1'b0) begin errors++; $display("FAIL basic_cmd_rdy got=%b%b exp=10", rdy_c0, rdy_c1); end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_a [4];
    exp_a[0] = 13'h1FFE; exp_a[1] = 13'h1FFF; exp_a[2] = 13'h0000; exp_a[3] = 13'h0001;
    apply_reset();
    run_burst(13'h1FFE, 13'd3, 1'b0, '0, '0);
    checks++; if (rd_cyc.size() != 4) begin errors++; $display("FAIL wrap_count got=%0d exp=4", rd_cyc.size()); end
    for (int i = 0; i < 4 && i < rd_addr.size(); i++) begin
      checks++;
      if (rd_addr[i] !== exp_a[i]) begin errors++; $display("FAIL wrap_addr%0d got=%h exp=%h", i, rd_addr[i], exp_a[i]); end
    end
  endtask

  task automatic test_stall();
    logic [127:0] sm;
    logic [127:0] hm;
    logic [DW-1:0] dat;
    logic [BW-1:0] be;
    logic ok;
    sm = '0; sm[2] = 1'b1; sm[3] = 1'b1;
    hm = '0; hm[2] = 1'b1;
    dat = {13{32'hDEADBEEF}};
    be  = 52'hF_0F0F_0F0F_0F0F;
    apply_reset();
    hw_addr = 13'h0AB; hw_data = dat; hw_be = be;
    run_burst(13'h040, 13'd7, 1'b0, sm, hm);
    checks++; if (rd_cyc.size() != 8) begin errors++; $display("FAIL stall_count got=%0d exp=8", rd_cyc.size()); end
    ok = 1'b1;
    for (int i = 0; i < rd_addr.size(); i++) if (rd_addr[i] !== 13'h040 + 13'(i)) ok = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL stall_contig got_first=%h exp contiguous from 040", rd_addr.size() > 0 ? rd_addr[0] : 13'h0); end
    checks++;
    if (rd_cyc.size() < 2 || rd_cyc[0] != 2 || rd_cyc[1] != 5) begin
      errors++;
      $display("FAIL stall_gap got=%0d,%0d exp=2,5", rd_cyc.size() > 0 ? rd_cyc[0] : -1, rd_cyc.size() > 1 ? rd_cyc[1] : -1);
    end
    checks++; if (done_cyc != 12) begin errors++; $display("FAIL stall_done got=%0d exp=12", done_cyc); end
    checks++; if (acc_cyc.size() != 1 || acc_cyc[0] != 2) begin errors++; $display("FAIL stall_hw_acc got_n=%0d first=%0d exp=1@2", acc_cyc.size(), acc_cyc.size() > 0 ? acc_cyc[0] : -1); end
    checks++;
    if (wr_cyc.size() != 1 || wr_cyc[0] != 3 || wr_addr_q[0] !== 13'h0AB || !wr_we_ok) begin
      errors++;
      $display("FAIL stall_wr_port got_n=%0d cyc=%0d addr=%h we_ok=%b exp=1@3 addr=0ab we=1",
               wr_cyc.size(), wr_cyc.size() > 0 ? wr_cyc[0] : -1, wr_addr_q.size() > 0 ? wr_addr_q[0] : 13'h0, wr_we_ok);
    end
    checks++; if (wr_data_last !== dat || wr_be_last !== be) begin errors++; $display("FAIL stall_wr_data got_be=%h exp_be=%h data_low=%h", wr_be_last, be, wr_data_last[31:0]); end
`ifdef WB_SCHED_PERF_EN
    checks++; if (perf_stall !== 32'd2) begin errors++; $display("FAIL stall_perf got=%0d exp=2", perf_stall); end
`else
    checks++; if (perf_stall !== 32'd0) begin errors++; $display("FAIL stall_perf got=%0d exp=0", perf_stall); end
`endif
  endtask

  task automatic test_steal();
    logic ok;
    int run_acc;
    apply_reset();
    hw_addr = 13'h111; hw_data = '0; hw_be = '1;
    run_burst(13'h100, 13'd63, 1'b0, '0, '1);
    checks++; if (rd_cyc.size() != 64) begin errors++; $display("FAIL steal_count got=%0d exp=64", rd_cyc.size()); end
    ok = 1'b1;
    for (int i = 0; i < rd_addr.size(); i++) if (rd_addr[i] !== 13'h100 + 13'(i)) ok = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL steal_contig got non-contiguous exp 100..13f"); end
    checks++;
    if (acc_cyc.size() < 4 || acc_cyc[0] != 0 || acc_cyc[1] != 17 || acc_cyc[2] != 34 || acc_cyc[3] != 51) begin
      errors++;
      $display("FAIL steal_acc_cycles got_n=%0d second=%0d exp 0,17,34,51", acc_cyc.size(), acc_cyc.size() > 1 ? acc_cyc[1] : -1);
    end
    checks++;
    if (rd_cyc.size() < 17 || rd_cyc[15] != 17 || rd_cyc[16] != 19) begin
      errors++;
      $display("FAIL steal_gap got=%0d,%0d exp=17,19", rd_cyc.size() > 15 ? rd_cyc[15] : -1, rd_cyc.size() > 16 ? rd_cyc[16] : -1);
    end
    run_acc = 0;
    foreach (acc_cyc[i]) if (acc_cyc[i] >= 1 && acc_cyc[i] <= 67) run_acc++;
    checks++; if (run_acc != 3) begin errors++; $display("FAIL steal_forced got=%0d exp=3", run_acc); end
    checks++; if (done_cyc != 69) begin errors++; $display("FAIL steal_done got=%0d exp=69", done_cyc); end
`ifdef WB_SCHED_PERF_EN
    checks++; if (perf_steal !== 32'd3) begin errors++; $display("FAIL steal_perf got=%0d exp=3", perf_steal); end
`else
    checks++; if (perf_steal !== 32'd0) begin errors++; $display("FAIL steal_perf got=%0d exp=0", perf_steal); end
`endif
  endtask

  task automatic test_bypass();
    apply_reset();
    run_burst(13'h020, 13'd1, 1'b1, '0, '0);
    checks++; if (rd_cyc.size() != 2) begin errors++; $display("FAIL bypass_count got=%0d exp=2", rd_cyc.size()); end
    for (int i = 0; i < rd_byp.size(); i++) begin
      checks++;
      if (rd_byp[i] !== 1'b1) begin errors++; $display("FAIL bypass_flag%0d got=%b exp=1", i, rd_byp[i]); end
    end
    checks++; if (done_cyc != 4) begin errors++; $display("FAIL bypass_done got=%0d exp=4", done_cyc); end
  endtask

  task automatic test_reset_mid();
    int strobes;
    apply_reset();
    @(posedge clk); #1;
    cmd_vld = 1'b1; cmd_base = 13'h200; cmd_len = 13'd20;
    @(posedge clk); #1;
    cmd_vld = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #4;
    checks++; if (rd_en !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL midrst_pre got_en=%b busy=%b exp=1/1", rd_en, busy); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #4;
    checks++;
    if (rd_en !== 1'b0 || bc_en !== 1'b0 || done !== 1'b0 || cmd_rdy !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_post got rd_en=%b bc_en=%b done=%b cmd_rdy=%b busy=%b exp 0,0,0,1,0",
               rd_en, bc_en, done, cmd_rdy, busy);
    end
    strobes = 0;
    repeat (4) begin @(posedge clk); #5; if (rd_en) strobes++; end
    checks++; if (strobes != 0) begin errors++; $display("FAIL midrst_quiet got=%0d exp=0", strobes); end
    $display("reset mid-burst applied");
    run_burst(13'h300, 13'd2, 1'b0, '0, '0);
    checks++;
    if (rd_addr.size() != 3 || rd_addr[0] !== 13'h300 || rd_addr[2] !== 13'h302) begin
      errors++;
      $display("FAIL midrst_restart got_n=%0d first=%h exp=3 from 300", rd_addr.size(), rd_addr.size() > 0 ? rd_addr[0] : 13'h0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_steal();
    test_bypass();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
